// File: rtl/tube_scan_reader.sv
// tube_scan_reader: readback monitor for a multiplexed seven-segment display bus.
// Qualifies each tube's segment pattern as stable, decodes it back to a digit,
// assembles one digit per tube into a frame, and hands completed frames out
// on a valid/ack handshake.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous active-high reset
//   seg_in       segment lines, bit0=a .. bit6=g, bit7=dp
//   sel_in       one-hot digit select, bit i = tube i
//   frame_value  decoded digits, nibble i = tube i (F = blank, E = illegal)
//   frame_dp     dp bit per tube
//   frame_err    per-tube illegal-pattern flag
//   frame_valid  frame outputs hold a completed, unacknowledged frame
//   frame_ack    consumer accepts the pending frame
//   overrun      sticky: a frame completed and was dropped while one was pending
module tube_scan_reader #(
    parameter int unsigned DIGITS        = 4,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            seg_in,
    input  logic [DIGITS-1:0]     sel_in,
    output logic [4*DIGITS-1:0]   frame_value,
    output logic [DIGITS-1:0]     frame_dp,
    output logic [DIGITS-1:0]     frame_err,
    output logic                  frame_valid,
    input  logic                  frame_ack,
    output logic                  overrun
);

    localparam int unsigned CNT_W  = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned HELD_W = DIGITS + 8;
    localparam int unsigned VAL_W  = 4 * DIGITS;

    typedef enum logic {
        ST_EMPTY   = 1'b0,
        ST_PENDING = 1'b1
    } state_e;

    // Returns {err, value}; only segments a..g take part in the decode.
    function automatic logic [4:0] decode_seg(input logic [6:0] seg);
        logic [4:0] r;
        case (seg)
            7'h3F:   r = 5'h00;
            7'h06:   r = 5'h01;
            7'h5B:   r = 5'h02;
            7'h4F:   r = 5'h03;
            7'h66:   r = 5'h04;
            7'h6D:   r = 5'h05;
            7'h7D:   r = 5'h06;
            7'h07:   r = 5'h07;
            7'h7F:   r = 5'h08;
            7'h6F:   r = 5'h09;
            7'h00:   r = 5'h0F;
            default: r = 5'h1E;
        endcase
        return r;
    endfunction

    logic [HELD_W-1:0] held_q, held_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              captured_q, captured_d;
    logic [DIGITS-1:0] seen_q, seen_d;
    logic [VAL_W-1:0]  slot_val_q, slot_val_d;
    logic [DIGITS-1:0] slot_dp_q, slot_dp_d;
    logic [DIGITS-1:0] slot_err_q, slot_err_d;
    state_e            state_q, state_d;
    logic [VAL_W-1:0]  frame_value_q, frame_value_d;
    logic [DIGITS-1:0] frame_dp_q, frame_dp_d;
    logic [DIGITS-1:0] frame_err_q, frame_err_d;
    logic              overrun_q, overrun_d;

    logic [DIGITS-1:0] held_sel;
    logic [7:0]        held_seg;
    logic [4:0]        dec;
    logic              in_diff;
    logic              sel_onehot;
    logic              capture;
    logic              complete;
    logic              load;

    assign held_sel   = held_q[HELD_W-1:8];
    assign held_seg   = held_q[7:0];
    assign dec        = decode_seg(held_seg[6:0]);
    assign in_diff    = ({sel_in, seg_in} != held_q);
    assign sel_onehot = (held_sel != '0) && ((held_sel & (held_sel - DIGITS'(1))) == '0);
    assign capture    = (cnt_q == CNT_W'(STABLE_CYCLES)) && !captured_q && sel_onehot;
    // Completion is seen one edge after the final capture fills seen.
    assign complete   = &seen_q;

    // Stability tracker: any input change restarts the dwell.
    always_comb begin
        held_d     = held_q;
        cnt_d      = cnt_q;
        captured_d = captured_q | capture;
        if (in_diff) begin
            held_d     = {sel_in, seg_in};
            cnt_d      = CNT_W'(1);
            captured_d = 1'b0;
        end else if (cnt_q != CNT_W'(STABLE_CYCLES)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Working slots and seen mask; seen restarts once a frame has completed.
    always_comb begin
        slot_val_d = slot_val_q;
        slot_dp_d  = slot_dp_q;
        slot_err_d = slot_err_q;
        seen_d     = complete ? '0 : seen_q;
        if (capture) begin
            for (int unsigned i = 0; i < DIGITS; i++) begin
                if (held_sel[i]) begin
                    slot_val_d[4*i +: 4] = dec[3:0];
                    slot_dp_d[i]         = held_seg[7];
                    slot_err_d[i]        = dec[4];
                    seen_d[i]            = 1'b1;
                end
            end
        end
    end

    // Handshake FSM: next state, overrun and frame load.
    always_comb begin
        state_d   = state_q;
        overrun_d = overrun_q;
        load      = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (complete) begin
                    load    = 1'b1;
                    state_d = ST_PENDING;
                end
            end
            ST_PENDING: begin
                if (frame_ack) begin
                    overrun_d = 1'b0;
                    if (complete) begin
                        load = 1'b1;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end else if (complete) begin
                    overrun_d = 1'b1;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        frame_value_d = load ? slot_val_q : frame_value_q;
        frame_dp_d    = load ? slot_dp_q  : frame_dp_q;
        frame_err_d   = load ? slot_err_q : frame_err_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            held_q        <= '0;
            cnt_q         <= '0;
            captured_q    <= 1'b0;
            seen_q        <= '0;
            slot_val_q    <= '0;
            slot_dp_q     <= '0;
            slot_err_q    <= '0;
            state_q       <= ST_EMPTY;
            frame_value_q <= '0;
            frame_dp_q    <= '0;
            frame_err_q   <= '0;
            overrun_q     <= 1'b0;
        end else begin
            held_q        <= held_d;
            cnt_q         <= cnt_d;
            captured_q    <= captured_d;
            seen_q        <= seen_d;
            slot_val_q    <= slot_val_d;
            slot_dp_q     <= slot_dp_d;
            slot_err_q    <= slot_err_d;
            state_q       <= state_d;
            frame_value_q <= frame_value_d;
            frame_dp_q    <= frame_dp_d;
            frame_err_q   <= frame_err_d;
            overrun_q     <= overrun_d;
        end
    end

    assign frame_value = frame_value_q;
    assign frame_dp    = frame_dp_q;
    assign frame_err   = frame_err_q;
    assign frame_valid = (state_q == ST_PENDING);
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_tube_scan_reader.sv
// Directed self-checking bench for tube_scan_reader (DIGITS=4, STABLE_CYCLES=4).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_tube_scan_reader;

    logic        clk;
    logic        reset;
    logic [7:0]  seg_in;
    logic [3:0]  sel_in;
    logic [15:0] frame_value;
    logic [3:0]  frame_dp;
    logic [3:0]  frame_err;
    logic        frame_valid;
    logic        frame_ack;
    logic        overrun;

    int pass_cnt  = 0;
    int total_cnt = 0;

    tube_scan_reader #(
        .DIGITS        (4),
        .STABLE_CYCLES (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .seg_in      (seg_in),
        .sel_in      (sel_in),
        .frame_value (frame_value),
        .frame_dp    (frame_dp),
        .frame_err   (frame_err),
        .frame_valid (frame_valid),
        .frame_ack   (frame_ack),
        .overrun     (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present {sel, seg} for n rising edges; starts and ends on a falling edge.
    task automatic dwell(input logic [3:0] sel, input logic [7:0] seg, input int n);
        sel_in = sel;
        seg_in = seg;
        repeat (n) @(negedge clk);
    endtask

    // Full 4-cycle scan of tubes 0..3.
    task automatic scan4(input logic [7:0] s0, input logic [7:0] s1,
                         input logic [7:0] s2, input logic [7:0] s3);
        dwell(4'b0001, s0, 4);
        dwell(4'b0010, s1, 4);
        dwell(4'b0100, s2, 4);
        dwell(4'b1000, s3, 4);
    endtask

    task automatic pulse_ack();
        frame_ack = 1'b1;
        @(negedge clk);
        frame_ack = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; frame_ack = 1'b0; sel_in = '0; seg_in = '0;
        repeat (2) @(negedge clk);
        total_cnt++; if (frame_value !== 16'h0) $display("FAIL reset_value got=%h exp=0000", frame_value); else pass_cnt++;
        total_cnt++; if ({frame_valid, overrun, frame_dp, frame_err} !== 10'b0) $display("FAIL reset_flags got=%b exp=0", {frame_valid, overrun, frame_dp, frame_err}); else pass_cnt++;
        reset = 1'b0;
        dwell(4'b0000, 8'h00, 6);
        total_cnt++; if (frame_valid !== 1'b0) $display("FAIL reset_idle_valid got=%b exp=0", frame_valid); else pass_cnt++;
    endtask

    task automatic test_basic_scan();
        scan4(8'h06, 8'h5B, 8'h4F, 8'h66);
        dwell(4'b0000, 8'h00, 1);
        total_cnt++; if (frame_valid !== 1'b0) $display("FAIL basic_valid_early got=%b exp=0", frame_valid); else pass_cnt++;
        dwell(4'b0000, 8'h00, 1);
        total_cnt++; if (frame_valid !== 1'b1) $display("FAIL basic_valid_rise got=%b exp=1", frame_valid); else pass_cnt++;
        total_cnt++; if (frame_value !== 16'h4321) $display("FAIL basic_value got=%h exp=4321", frame_value); else pass_cnt++;
        total_cnt++; if ({frame_err, frame_dp, overrun} !== 9'b0) $display("FAIL basic_flags got=%b exp=0", {frame_err, frame_dp, overrun}); else pass_cnt++;
        dwell(4'b0000, 8'h00, 10);
        total_cnt++; if ({frame_valid, frame_value} !== {1'b1, 16'h4321}) $display("FAIL basic_frozen got=%h exp=14321", {frame_valid, frame_value}); else pass_cnt++;
        pulse_ack();
        total_cnt++; if (frame_valid !== 1'b0) $display("FAIL basic_ack got=%b exp=0", frame_valid); else pass_cnt++;
        pulse_ack();
        total_cnt++; if ({frame_valid, overrun} !== 2'b00) $display("FAIL ack_in_empty got=%b exp=00", {frame_valid, overrun}); else pass_cnt++;
    endtask

    task automatic test_short_dwell();
        dwell(4'b0001, 8'h06, 4);
        dwell(4'b0010, 8'h5B, 4);
        dwell(4'b0100, 8'h7F, 3);
        dwell(4'b1000, 8'h66, 4);
        dwell(4'b0000, 8'h00, 3);
        total_cnt++; if (frame_valid !== 1'b0) $display("FAIL short_no_capture got=%b exp=0", frame_valid); else pass_cnt++;
        dwell(4'b0100, 8'h4F, 4);
        dwell(4'b0000, 8'h00, 2);
        total_cnt++; if ({frame_valid, frame_value} !== {1'b1, 16'h4321}) $display("FAIL short_value got=%h exp=14321", {frame_valid, frame_value}); else pass_cnt++;
        pulse_ack();
    endtask

    task automatic test_illegal();
        scan4(8'h3F, 8'h49, 8'h7D, 8'h6F);
        dwell(4'b0000, 8'h00, 2);
        total_cnt++; if (frame_value !== 16'h96E0) $display("FAIL illegal_value got=%h exp=96e0", frame_value); else pass_cnt++;
        total_cnt++; if (frame_err !== 4'b0010) $display("FAIL illegal_err got=%b exp=0010", frame_err); else pass_cnt++;
        pulse_ack();
    endtask

    task automatic test_blank_dp();
        scan4(8'h5B, 8'h07, 8'h7F, 8'h80);
        dwell(4'b0000, 8'h00, 2);
        total_cnt++; if (frame_value !== 16'hF872) $display("FAIL blank_value got=%h exp=f872", frame_value); else pass_cnt++;
        total_cnt++; if ({frame_dp, frame_err} !== 8'b1000_0000) $display("FAIL blank_dp_err got=%b exp=10000000", {frame_dp, frame_err}); else pass_cnt++;
        pulse_ack();
    endtask

    task automatic test_overrun();
        scan4(8'h06, 8'h5B, 8'h4F, 8'h66);
        dwell(4'b0000, 8'h00, 2);
        scan4(8'h6D, 8'h7D, 8'h07, 8'h7F);
        dwell(4'b0000, 8'h00, 2);
        total_cnt++; if (frame_value !== 16'h4321) $display("FAIL overrun_frozen got=%h exp=4321", frame_value); else pass_cnt++;
        total_cnt++; if ({frame_valid, overrun} !== 2'b11) $display("FAIL overrun_set got=%b exp=11", {frame_valid, overrun}); else pass_cnt++;
        dwell(4'b0000, 8'h00, 5);
        total_cnt++; if (overrun !== 1'b1) $display("FAIL overrun_sticky got=%b exp=1", overrun); else pass_cnt++;
        pulse_ack();
        total_cnt++; if ({frame_valid, overrun} !== 2'b00) $display("FAIL overrun_clear got=%b exp=00", {frame_valid, overrun}); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        scan4(8'h06, 8'h5B, 8'h4F, 8'h66);
        dwell(4'b0000, 8'h00, 2);
        scan4(8'h6D, 8'h7D, 8'h07, 8'h7F);
        dwell(4'b0000, 8'h00, 2);
        total_cnt++; if (overrun !== 1'b1) $display("FAIL b2b_pre_overrun got=%b exp=1", overrun); else pass_cnt++;
        scan4(8'h6F, 8'h3F, 8'h06, 8'h5B);
        dwell(4'b0000, 8'h00, 1);
        pulse_ack();
        total_cnt++; if ({frame_valid, overrun} !== 2'b10) $display("FAIL b2b_flags got=%b exp=10", {frame_valid, overrun}); else pass_cnt++;
        total_cnt++; if (frame_value !== 16'h2109) $display("FAIL b2b_value got=%h exp=2109", frame_value); else pass_cnt++;
        pulse_ack();
    endtask

    task automatic test_multi_hot();
        dwell(4'b0001, 8'h06, 4);
        dwell(4'b0110, 8'h06, 10);
        dwell(4'b1000, 8'h66, 4);
        dwell(4'b0000, 8'h00, 3);
        total_cnt++; if (frame_valid !== 1'b0) $display("FAIL multihot_no_capture got=%b exp=0", frame_valid); else pass_cnt++;
        dwell(4'b0010, 8'h5B, 4);
        dwell(4'b0100, 8'h4F, 4);
        dwell(4'b0000, 8'h00, 2);
        total_cnt++; if ({frame_valid, frame_value} !== {1'b1, 16'h4321}) $display("FAIL multihot_value got=%h exp=14321", {frame_valid, frame_value}); else pass_cnt++;
        pulse_ack();
    endtask

    task automatic test_reset_mid_frame();
        scan4(8'h06, 8'h5B, 8'h4F, 8'h66);
        dwell(4'b0000, 8'h00, 2);
        scan4(8'h6D, 8'h7D, 8'h07, 8'h7F);
        dwell(4'b0000, 8'h00, 2);
        dwell(4'b0001, 8'h3F, 4);
        dwell(4'b0010, 8'h3F, 4);
        dwell(4'b0000, 8'h00, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        total_cnt++; if (frame_value !== 16'h0) $display("FAIL midreset_value got=%h exp=0000", frame_value); else pass_cnt++;
        total_cnt++; if ({frame_valid, overrun, frame_dp, frame_err} !== 10'b0) $display("FAIL midreset_flags got=%b exp=0", {frame_valid, overrun, frame_dp, frame_err}); else pass_cnt++;
        dwell(4'b0100, 8'h7D, 4);
        dwell(4'b1000, 8'h07, 4);
        dwell(4'b0000, 8'h00, 3);
        total_cnt++; if (frame_valid !== 1'b0) $display("FAIL midreset_seen_cleared got=%b exp=0", frame_valid); else pass_cnt++;
        dwell(4'b0001, 8'h6D, 4);
        dwell(4'b0010, 8'h66, 4);
        dwell(4'b0000, 8'h00, 2);
        total_cnt++; if ({frame_valid, frame_value} !== {1'b1, 16'h7645}) $display("FAIL midreset_value_after got=%h exp=17645", {frame_valid, frame_value}); else pass_cnt++;
        pulse_ack();
    endtask

    initial begin
        test_reset();
        test_basic_scan();
        test_short_dwell();
        test_illegal();
        test_blank_dp();
        test_overrun();
        test_back_to_back();
        test_multi_hot();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
